rf_write_arbiter: RTL and testbench
===================================

RF_WRITE_ARBITER -- requirements
Module: rf_write_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, number of buffered multi-cycle results (power of two, >=2).
REQ-002 Parameter STARVE_LIMIT, default 4, cycles a buffered result may wait before the pipeline is frozen.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 wb_valid_i  input  1  WB stage presents a register write this cycle.
REQ-006 wb_rd_addr_i  input  5  WB destination register.
REQ-007 wb_rd_data_i  input  32  WB write data (WB stage rd_data output).
REQ-008 mdu_valid_i  input  1  multi-cycle unit offers a result.
REQ-009 mdu_ready_o  output  1  arbiter accepts the MDU result this cycle.
REQ-010 mdu_rd_addr_i  input  5  MDU destination register.
REQ-011 mdu_rd_data_i  input  32  MDU result data.
REQ-012 rf_we_o  output  1  register-file write enable.
REQ-013 rf_waddr_o  output  5  register-file write address.
REQ-014 rf_wdata_o  output  32  register-file write data.
REQ-015 wb_stall_o  output  1  registered; freezes the pipeline so the FIFO head owns the write port.
REQ-016 fifo_count_o  output  clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-017 The block SHALL grant exactly zero or one register-file write per cycle.
REQ-018 A WB request SHALL be eligible only when wb_valid_i=1, wb_rd_addr_i!=0 and wb_stall_o=0.
REQ-019 Grant priority SHALL be: eligible WB request, else FIFO head if fifo_count_o>0, else no write.
REQ-020 On a WB grant rf_we_o=1, rf_waddr_o/rf_wdata_o SHALL equal wb_rd_addr_i/wb_rd_data_i combinationally in the same cycle.
REQ-021 On a FIFO grant rf_we_o=1, outputs SHALL equal the head entry, and the head SHALL be popped at the clock edge.
REQ-022 With no grant rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0.
REQ-023 mdu_ready_o SHALL be 1 iff fifo_count_o<FIFO_DEPTH, or fifo_count_o=FIFO_DEPTH and the head is granted this cycle.
REQ-024 On mdu_valid_i & mdu_ready_o with mdu_rd_addr_i!=0, the result SHALL be pushed at the clock edge; it is writable no earlier than the next cycle (no bypass).
REQ-025 An MDU handshake with mdu_rd_addr_i=0 SHALL complete but push nothing.
REQ-026 Simultaneous push and pop SHALL leave fifo_count_o unchanged; pointers wrap modulo FIFO_DEPTH; FIFO order is strictly preserved.
REQ-027 Starvation counter: SHALL increment each cycle fifo_count_o>0 and the head is not granted, saturating at STARVE_LIMIT; clear to 0 on any FIFO grant or when empty.
REQ-028 wb_stall_o SHALL be set at the edge where the counter reaches STARVE_LIMIT, and SHALL clear at the edge following the FIFO grant it enables.
REQ-029 While wb_stall_o=1 the FIFO head SHALL be granted regardless of wb_valid_i; the WB request is held by the pipeline, not dropped or buffered.
REQ-030 Write-after-write ordering between WB and MDU for the same rd SHALL be guaranteed by issue logic; the arbiter does not compare addresses.

Reset
REQ-031 While rst=1: FIFO emptied (fifo_count_o=0), pointers=0, starvation counter=0, wb_stall_o=0, rf_we_o=0, mdu_ready_o=0.
REQ-032 Reset asserted mid-operation SHALL discard all buffered results with no register-file write in or after the reset cycle.
REQ-033 First cycle after rst deasserts, mdu_ready_o=1 and WB requests SHALL be granted normally.

Verification
REQ-034 WB only: wb_valid_i=1, rd=5, data=0xDEADBEEF -> rf_we_o=1, waddr=5, wdata=0xDEADBEEF same cycle; rd=0 -> rf_we_o=0.
REQ-035 MDU idle-port: push rd=7, data=0x12 with wb_valid_i=0 -> next cycle rf_we_o=1, waddr=7, data=0x12, fifo_count_o back to 0.
REQ-036 Full FIFO: two MDU pushes while WB busy every cycle -> fifo_count_o=2, mdu_ready_o=0; on first FIFO grant mdu_ready_o=1 same cycle and a third push keeps count=2.
REQ-037 Starvation: one entry queued, WB valid continuously -> counter hits 4, wb_stall_o=1 next cycle, head written that cycle, wb_stall_o=0 following cycle, WB resumes.
REQ-038 Reset mid-operation: FIFO holding 2 entries, assert rst asynchronously between edges -> rf_we_o, wb_stall_o, fifo_count_o go 0 immediately; no buffered entry ever written after release.
REQ-039 Random WB/MDU traffic against a reference queue model: every nonzero-rd MDU result written exactly once in order, never two writes in one cycle.

Source files
------------

// File: rtl/rf_write_arbiter.sv
// Register-file write-port arbiter: WB stage has priority, multi-cycle results are
// buffered in a small FIFO and a starvation guard freezes WB so the FIFO head drains.
module rf_write_arbiter #(
    parameter int unsigned FIFO_DEPTH   = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wb_valid_i,
    input  logic [4:0]                    wb_rd_addr_i,
    input  logic [31:0]                   wb_rd_data_i,
    input  logic                          mdu_valid_i,
    output logic                          mdu_ready_o,
    input  logic [4:0]                    mdu_rd_addr_i,
    input  logic [31:0]                   mdu_rd_data_i,
    output logic                          rf_we_o,
    output logic [4:0]                    rf_waddr_o,
    output logic [31:0]                   rf_wdata_o,
    output logic                          wb_stall_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
    } rf_wr_t;

    rf_wr_t          mem [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;
    logic [SW-1:0]   starve_q;
    logic [SW-1:0]   starve_d;
    logic            stall_q;
    logic            stall_d;

    logic            wb_elig;
    logic            wb_grant;
    logic            fifo_grant;
    logic            push;
    logic            fifo_nonempty;
    rf_wr_t          head;

    // Grant selection; every request path is masked while reset is held.
    always_comb begin
        fifo_nonempty = (count != '0);
        head          = mem[rd_ptr];
        wb_elig       = wb_valid_i && (wb_rd_addr_i != 5'd0) && !stall_q;
        wb_grant      = !rst && wb_elig;
        fifo_grant    = !rst && !wb_elig && fifo_nonempty;
        mdu_ready_o   = !rst && ((count < CW'(FIFO_DEPTH)) || fifo_grant);
        push          = mdu_valid_i && mdu_ready_o && (mdu_rd_addr_i != 5'd0);
    end

    always_comb begin
        rf_we_o    = 1'b0;
        rf_waddr_o = 5'd0;
        rf_wdata_o = 32'd0;
        if (wb_grant) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = wb_rd_addr_i;
            rf_wdata_o = wb_rd_data_i;
        end else if (fifo_grant) begin
            rf_we_o    = 1'b1;
            rf_waddr_o = head.addr;
            rf_wdata_o = head.data;
        end
    end

    // Starvation counter saturates; stall rises when it reaches the limit and
    // drops after the head write that the stall forced.
    always_comb begin
        starve_d = starve_q;
        if (!fifo_nonempty || fifo_grant) begin
            starve_d = '0;
        end else if (starve_q != SW'(STARVE_LIMIT)) begin
            starve_d = starve_q + SW'(1);
        end
        stall_d = stall_q ? !fifo_grant : (starve_d == SW'(STARVE_LIMIT));
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= '{addr: mdu_rd_addr_i, data: mdu_rd_data_i};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            starve_q <= '0;
            stall_q  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= AW'(wr_ptr + AW'(1));
            end
            if (fifo_grant) begin
                rd_ptr <= AW'(rd_ptr + AW'(1));
            end
            case ({push, fifo_grant})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            starve_q <= starve_d;
            stall_q  <= stall_d;
        end
    end

    // Stall and occupancy are forced low combinationally while reset is held.
    assign wb_stall_o   = stall_q && !rst;
    assign fifo_count_o = rst ? '0 : count;

endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed bench for rf_write_arbiter: a scoreboard queue of expected writes
// checked by an independent monitor, plus per-cycle control-signal checks.
module tb_rf_write_arbiter;

    logic        clk;
    logic        rst;
    logic        wb_valid_i;
    logic [4:0]  wb_rd_addr_i;
    logic [31:0] wb_rd_data_i;
    logic        mdu_valid_i;
    logic        mdu_ready_o;
    logic [4:0]  mdu_rd_addr_i;
    logic [31:0] mdu_rd_data_i;
    logic        rf_we_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;
    logic        wb_stall_o;
    logic [1:0]  fifo_count_o;

    int n_tests = 0;
    int n_fail  = 0;
    logic [36:0] exp_q [$];

    rf_write_arbiter #(.FIFO_DEPTH(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .wb_valid_i(wb_valid_i), .wb_rd_addr_i(wb_rd_addr_i), .wb_rd_data_i(wb_rd_data_i),
        .mdu_valid_i(mdu_valid_i), .mdu_ready_o(mdu_ready_o),
        .mdu_rd_addr_i(mdu_rd_addr_i), .mdu_rd_data_i(mdu_rd_data_i),
        .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o),
        .wb_stall_o(wb_stall_o), .fifo_count_o(fifo_count_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic exp_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    // Monitor: every register-file write must match the next expected entry.
    always @(negedge clk) begin
        if (rf_we_o === 1'b1) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d data %0h, expected none at %0t",
                         rf_waddr_o, rf_wdata_o, $time);
            end else begin
                logic [36:0] e;
                e = exp_q.pop_front();
                if ({rf_waddr_o, rf_wdata_o} !== e) begin
                    n_fail++;
                    $display("FAIL write_data: got addr %0d data %0h, expected addr %0d data %0h at %0t",
                             rf_waddr_o, rf_wdata_o, e[36:32], e[31:0], $time);
                end
            end
        end
    end

    // One cycle: drive at posedge+1, check control outputs at negedge.
    task automatic step(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                        input logic mv, input logic [4:0] ma, input logic [31:0] md,
                        input logic e_we, input logic e_rdy, input logic [1:0] e_cnt,
                        input logic e_stall);
        wb_valid_i    = wv;
        wb_rd_addr_i  = wa;
        wb_rd_data_i  = wd;
        mdu_valid_i   = mv;
        mdu_rd_addr_i = ma;
        mdu_rd_data_i = md;
        @(negedge clk);
        chk("rf_we", 32'(rf_we_o), 32'(e_we));
        chk("mdu_ready", 32'(mdu_ready_o), 32'(e_rdy));
        chk("fifo_count", 32'(fifo_count_o), 32'(e_cnt));
        chk("wb_stall", 32'(wb_stall_o), 32'(e_stall));
        if (!e_we) begin
            chk("idle_waddr", 32'(rf_waddr_o), 32'd0);
            chk("idle_wdata", rf_wdata_o, 32'd0);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        wb_valid_i = 1'b1; wb_rd_addr_i = 5'd5; wb_rd_data_i = 32'h1111_1111;
        mdu_valid_i = 1'b1; mdu_rd_addr_i = 5'd3; mdu_rd_data_i = 32'h2222_2222;
        @(negedge clk);
        @(negedge clk);
        chk("rst_we", 32'(rf_we_o), 32'd0);
        chk("rst_ready", 32'(mdu_ready_o), 32'd0);
        chk("rst_count", 32'(fifo_count_o), 32'd0);
        chk("rst_stall", 32'(wb_stall_o), 32'd0);
        wb_valid_i = 1'b0; mdu_valid_i = 1'b0;
        @(posedge clk);
        #1 rst = 1'b0;

        // WB only, then rd=0 never writes
        exp_wr(5'd5, 32'hDEAD_BEEF);
        step(1, 5'd5, 32'hDEAD_BEEF, 0, 5'd0, 32'h0, 1, 1, 2'd0, 0);
        step(1, 5'd0, 32'h0000_1234, 0, 5'd0, 32'h0, 0, 1, 2'd0, 0);

        // MDU on idle port: written the following cycle
        step(0, 5'd0, 32'h0, 1, 5'd7, 32'h12, 0, 1, 2'd0, 0);
        exp_wr(5'd7, 32'h12);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 2'd1, 0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 2'd0, 0);

        // Fill FIFO under WB traffic, then push during the first head grant
        exp_wr(5'd1, 32'hA1);
        step(1, 5'd1, 32'hA1, 1, 5'd8, 32'h80, 1, 1, 2'd0, 0);
        exp_wr(5'd2, 32'hA2);
        step(1, 5'd2, 32'hA2, 1, 5'd9, 32'h90, 1, 1, 2'd1, 0);
        exp_wr(5'd3, 32'hA3);
        step(1, 5'd3, 32'hA3, 1, 5'd10, 32'hA0, 1, 0, 2'd2, 0);
        exp_wr(5'd8, 32'h80);
        step(0, 5'd0, 32'h0, 1, 5'd10, 32'hA0, 1, 1, 2'd2, 0);
        exp_wr(5'd9, 32'h90);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 2'd2, 0);
        exp_wr(5'd10, 32'hA0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 1, 1, 2'd1, 0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 2'd0, 0);

        // Starvation: WB valid every cycle, stall forces the head out
        exp_wr(5'd4, 32'hB0);
        step(1, 5'd4, 32'hB0, 1, 5'd12, 32'hC0, 1, 1, 2'd0, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_wr(5'd4, 32'hB0 + 32'(i));
            step(1, 5'd4, 32'hB0 + 32'(i), 0, 5'd0, 32'h0, 1, 1, 2'd1, 0);
        end
        exp_wr(5'd12, 32'hC0);
        step(1, 5'd4, 32'hB5, 0, 5'd0, 32'h0, 1, 1, 2'd1, 1);
        exp_wr(5'd4, 32'hB5);
        step(1, 5'd4, 32'hB5, 0, 5'd0, 32'h0, 1, 1, 2'd0, 0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 2'd0, 0);

        // MDU handshake to x0 pushes nothing
        step(0, 5'd0, 32'h0, 1, 5'd0, 32'hFF, 0, 1, 2'd0, 0);
        step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 2'd0, 0);

        // Reset mid-operation with two buffered entries
        exp_wr(5'd6, 32'hE0);
        step(1, 5'd6, 32'hE0, 1, 5'd13, 32'hD0, 1, 1, 2'd0, 0);
        exp_wr(5'd6, 32'hE1);
        step(1, 5'd6, 32'hE1, 1, 5'd14, 32'hD1, 1, 1, 2'd1, 0);
        exp_wr(5'd6, 32'hE2);
        step(1, 5'd6, 32'hE2, 0, 5'd0, 32'h0, 1, 0, 2'd2, 0);
        wb_valid_i = 1'b0; mdu_valid_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_we", 32'(rf_we_o), 32'd0);
        chk("arst_stall", 32'(wb_stall_o), 32'd0);
        chk("arst_count", 32'(fifo_count_o), 32'd0);
        chk("arst_ready", 32'(mdu_ready_o), 32'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(0, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 1, 2'd0, 0);
        end

        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
